// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DONE  = 2'd3
   } arb_state_t;

   typedef enum logic {
      OWN_CORE = 1'b0,
      OWN_DBG  = 1'b1
   } owner_t;

   // core_ctrl bit positions
   localparam int CTRL_RD = 1;
   localparam int CTRL_WR = 0;

   // width of the latency and starvation counters
   localparam int CNT_W = 4;

endpackage

// File: rtl/dmem_arb_pick.sv
// Priority select between core and debug, with a starvation counter that
// forces a debug grant after STARVE_MAX consecutive core grants.
module dmem_arb_pick
   import dmem_arb_pkg::*;
#(
   parameter int STARVE_MAX = 4
) (
   input  logic clk,
   input  logic reset_n,
   input  logic core_pend,
   input  logic dbg_pend,
   input  logic grant_en,
   output logic grant_dbg
);

   localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

   logic [CNT_W-1:0] starve_cnt;

   // core wins unless debug has been passed over STARVE_MAX times
   always_comb begin
      grant_dbg = dbg_pend && (!core_pend || (starve_cnt == STARVE_LIM));
   end

   // count core grants made while debug waits; clear when debug is idle or served
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         starve_cnt <= '0;
      end else if (grant_en) begin
         if (!dbg_pend || grant_dbg) begin
            starve_cnt <= '0;
         end else if (starve_cnt != STARVE_LIM) begin
            starve_cnt <= starve_cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data-memory controller shared by the MEM stage and a debug port.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | no access in flight; pick an owner if anyone is pending
// ST_ISSUE | mem_en strobe cycle; load latency counter
// ST_WAIT  | MEM_LAT cycles; read data captured on the last one
// ST_DONE  | release core stall or pulse dbg_ack; never re-grants here
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int MEM_LAT    = 2,
   parameter int STARVE_MAX = 4
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [1:0]  core_ctrl,
   input  logic [31:0] core_addr,
   input  logic [31:0] core_wdata,
   output logic        core_stall,
   output logic [31:0] core_rdata,
   input  logic        dbg_req,
   input  logic        dbg_we,
   input  logic [31:0] dbg_addr,
   input  logic [31:0] dbg_wdata,
   output logic        dbg_ack,
   output logic [31:0] dbg_rdata,
   output logic        mem_en,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);

   localparam logic [CNT_W-1:0] LAT_INIT = CNT_W'(MEM_LAT);

   arb_state_t       state;
   owner_t           owner;
   logic             acc_we;
   logic [CNT_W-1:0] wait_cnt;
   logic             core_pend;
   logic             grant_dbg;
   logic             sel_we;

   // request decode and the write flag of whichever side would win
   always_comb begin
      core_pend = (core_ctrl != 2'b00);
      sel_we    = grant_dbg ? dbg_we : core_ctrl[CTRL_WR];
   end

   dmem_arb_pick #(
      .STARVE_MAX (STARVE_MAX)
   ) u_pick (
      .clk       (clk),
      .reset_n   (reset_n),
      .core_pend (core_pend),
      .dbg_pend  (dbg_req),
      .grant_en  (state == ST_IDLE),
      .grant_dbg (grant_dbg)
   );

   // stall the pipeline until the core's own DONE cycle
   always_comb begin
      core_stall = core_pend && !((state == ST_DONE) && (owner == OWN_CORE));
   end

   // access sequencer with registered memory-side and response outputs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= ST_IDLE;
         owner      <= OWN_CORE;
         acc_we     <= 1'b0;
         wait_cnt   <= '0;
         mem_en     <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         core_rdata <= '0;
         dbg_rdata  <= '0;
         dbg_ack    <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (core_pend || dbg_req) begin
                  owner     <= grant_dbg ? OWN_DBG : OWN_CORE;
                  mem_addr  <= grant_dbg ? dbg_addr : core_addr;
                  mem_wdata <= grant_dbg ? dbg_wdata : core_wdata;
                  acc_we    <= sel_we;
                  mem_en    <= 1'b1;
                  mem_we    <= sel_we;
                  state     <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               mem_en   <= 1'b0;
               mem_we   <= 1'b0;
               wait_cnt <= LAT_INIT;
               state    <= ST_WAIT;
            end
            ST_WAIT: begin
               wait_cnt <= wait_cnt - 1'b1;
               if (wait_cnt == CNT_W'(1)) begin
                  if (!acc_we) begin
                     if (owner == OWN_CORE) core_rdata <= mem_rdata;
                     else                   dbg_rdata  <= mem_rdata;
                  end
                  dbg_ack <= (owner == OWN_DBG);
                  state   <= ST_DONE;
               end
            end
            ST_DONE: begin
               dbg_ack <= 1'b0;
               state   <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: one instance at MEM_LAT=2/STARVE_MAX=2 with a
// scoreboarded memory model, one at MEM_LAT=1 for the short-latency case.
module tb_dmem_arbiter;

   localparam int LAT_A = 2;
   localparam int STV_A = 2;
   localparam int LAT_B = 1;
   localparam logic [31:0] GARBAGE = 32'hBAD0_BAD0;

   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [31:0] wdata;
   } acc_t;

   logic        clk = 1'b0;
   logic        reset_n, reset_n_b;
   logic [1:0]  core_ctrl;
   logic [31:0] core_addr, core_wdata;
   logic        dbg_req, dbg_we;
   logic [31:0] dbg_addr, dbg_wdata;

   logic        core_stall, dbg_ack, mem_en, mem_we;
   logic [31:0] core_rdata, dbg_rdata, mem_addr, mem_wdata, mem_rdata;

   logic        core_stall_b, dbg_ack_b, mem_en_b, mem_we_b;
   logic [31:0] core_rdata_b, dbg_rdata_b, mem_addr_b, mem_wdata_b, mem_rdata_b;

   acc_t        acc_q[$];
   logic [31:0] core_q[$];
   logic [31:0] dbg_q[$];
   logic [31:0] mem [logic [31:0]];

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   dmem_arbiter #(.MEM_LAT(LAT_A), .STARVE_MAX(STV_A)) u_dut (
      .clk(clk), .reset_n(reset_n),
      .core_ctrl(core_ctrl), .core_addr(core_addr), .core_wdata(core_wdata),
      .core_stall(core_stall), .core_rdata(core_rdata),
      .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
      .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   dmem_arbiter #(.MEM_LAT(LAT_B), .STARVE_MAX(4)) u_dut_b (
      .clk(clk), .reset_n(reset_n_b),
      .core_ctrl(core_ctrl), .core_addr(core_addr), .core_wdata(core_wdata),
      .core_stall(core_stall_b), .core_rdata(core_rdata_b),
      .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
      .dbg_ack(dbg_ack_b), .dbg_rdata(dbg_rdata_b),
      .mem_en(mem_en_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
      .mem_rdata(mem_rdata_b)
   );

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      if (mem.exists(a)) return mem[a];
      return a ^ 32'h5A5A_0000;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h want 0x%08h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic cyc();
      @(negedge clk);
   endtask

   // memory model for instance A: checks every strobe against acc_q and
   // returns read data exactly LAT_A cycles after the mem_en cycle
   int          lat_a = 0;
   logic [31:0] data_a;
   acc_t        acc_e;
   always @(negedge clk) begin
      if (lat_a > 0) begin
         lat_a--;
         mem_rdata = (lat_a == 0) ? data_a : GARBAGE;
      end else begin
         mem_rdata = GARBAGE;
      end
      check("we_only_with_en", {31'b0, mem_we & ~mem_en}, 32'd0);
      if (mem_en) begin
         check("acc_q_nonempty", 32'(acc_q.size() > 0), 32'd1);
         if (acc_q.size() > 0) begin
            acc_e = acc_q.pop_front();
            check("acc_addr", mem_addr, acc_e.addr);
            check("acc_we", {31'b0, mem_we}, {31'b0, acc_e.we});
            if (acc_e.we) check("acc_wdata", mem_wdata, acc_e.wdata);
         end
         if (mem_we) mem[mem_addr] = mem_wdata;
         else        data_a = mem_rd(mem_addr);
         lat_a = LAT_A;
      end
   end

   // memory model for instance B
   int          lat_b = 0;
   logic [31:0] data_b;
   always @(negedge clk) begin
      if (lat_b > 0) begin
         lat_b--;
         mem_rdata_b = (lat_b == 0) ? data_b : GARBAGE;
      end else begin
         mem_rdata_b = GARBAGE;
      end
      if (mem_en_b) begin
         if (mem_we_b) mem[mem_addr_b] = mem_wdata_b;
         else          data_b = mem_rd(mem_addr_b);
         lat_b = LAT_B;
      end
   end

   // completion monitor: pop expected results when the DUT reports them
   logic [31:0] exp_v;
   always @(negedge clk) begin
      #2;
      if (reset_n && core_ctrl != 2'b00 && !core_stall) begin
         check("core_q_nonempty", 32'(core_q.size() > 0), 32'd1);
         if (core_q.size() > 0) begin
            exp_v = core_q.pop_front();
            check("sb_core_rdata", core_rdata, exp_v);
         end
      end
      if (dbg_ack) begin
         check("dbg_q_nonempty", 32'(dbg_q.size() > 0), 32'd1);
         if (dbg_q.size() > 0) begin
            exp_v = dbg_q.pop_front();
            check("sb_dbg_rdata", dbg_rdata, exp_v);
         end
      end
   end

   task automatic run_core(input logic [1:0] ctrl, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] exp_rd);
      cyc();
      core_ctrl = ctrl; core_addr = addr; core_wdata = wdata;
      core_q.push_back(exp_rd);
      acc_q.push_back('{addr, ctrl[0], wdata});
      #1;
      check("core_stall_c0", {31'b0, core_stall}, 32'd1);
      cyc(); #1;
      check("core_stall_c1", {31'b0, core_stall}, 32'd1);
      check("core_mem_en_c1", {31'b0, mem_en}, 32'd1);
      check("core_mem_we_c1", {31'b0, mem_we}, {31'b0, ctrl[0]});
      check("core_mem_addr_c1", mem_addr, addr);
      if (ctrl[0]) check("core_mem_wdata_c1", mem_wdata, wdata);
      for (int c = 2; c <= LAT_A + 1; c++) begin
         cyc(); #1;
         check("core_stall_wait", {31'b0, core_stall}, 32'd1);
         check("core_mem_en_wait", {31'b0, mem_en}, 32'd0);
      end
      cyc(); #1;
      check("core_stall_done", {31'b0, core_stall}, 32'd0);
      check("core_rdata_done", core_rdata, exp_rd);
      cyc();
      core_ctrl = 2'b00;
   endtask

   // called right after dbg_req is (still) high at a negedge in IDLE
   task automatic wait_dbg_ack(input string tag, input int exp_c, input logic [31:0] exp_rd);
      int got = -1;
      int n_ack = 0;
      for (int c = 0; c < 12; c++) begin
         if (c > 0) begin
            cyc();
            if (got >= 0) dbg_req = 1'b0;
         end
         #1;
         if (dbg_ack) begin
            if (got < 0) got = c;
            n_ack++;
         end
      end
      check({tag, "_ack_cycle"}, 32'(got), 32'(exp_c));
      check({tag, "_ack_count"}, 32'(n_ack), 32'd1);
      check({tag, "_rdata_held"}, dbg_rdata, exp_rd);
   endtask

   task automatic run_dbg(input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp_rd);
      cyc();
      dbg_req = 1'b1; dbg_we = we; dbg_addr = addr; dbg_wdata = wdata;
      acc_q.push_back('{addr, we, wdata});
      dbg_q.push_back(exp_rd);
      wait_dbg_ack(we ? "dbg_wr" : "dbg_rd", LAT_A + 2, exp_rd);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
      $fatal(1, "watchdog expired");
   end

   logic [31:0] st_addr [3];
   int          done_at [3];
   int          ack_at, idx;
   logic        done_prev, ack_prev;

   initial begin
      reset_n = 1'b0; reset_n_b = 1'b0;
      core_ctrl = 2'b00; core_addr = '0; core_wdata = '0;
      dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
      mem[32'h100] = 32'hDEAD_BEEF;
      mem[32'h200] = 32'hCAFE_F00D;

      cyc(); cyc(); #1;
      check("rst_mem_en", {31'b0, mem_en}, 32'd0);
      check("rst_mem_addr", mem_addr, 32'd0);
      check("rst_dbg_ack", {31'b0, dbg_ack}, 32'd0);
      check("rst_core_rdata", core_rdata, 32'd0);
      check("rst_core_stall", {31'b0, core_stall}, 32'd0);
      cyc(); reset_n = 1'b1;
      cyc(); cyc();

      // core load, stores (01 and 11), read-back of a stored word
      run_core(2'b10, 32'h100, 32'h0, 32'hDEAD_BEEF);
      run_core(2'b01, 32'h40, 32'h1234_5678, 32'hDEAD_BEEF);
      run_core(2'b11, 32'h44, 32'h9ABC_DEF0, 32'hDEAD_BEEF);
      run_core(2'b10, 32'h40, 32'h0, 32'h1234_5678);

      // simultaneous core load and debug read: core first, then debug
      cyc();
      core_ctrl = 2'b10; core_addr = 32'h104;
      dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h200;
      acc_q.push_back('{32'h104, 1'b0, 32'h0});
      acc_q.push_back('{32'h200, 1'b0, 32'h0});
      core_q.push_back(32'h5A5A_0104);
      dbg_q.push_back(32'hCAFE_F00D);
      for (int c = 0; c <= 10; c++) begin
         if (c > 0) cyc();
         if (c == 5)  core_ctrl = 2'b00;
         if (c == 10) dbg_req = 1'b0;
         #1;
         check("sim_stall", {31'b0, core_stall}, 32'(c <= 3));
         check("sim_mem_en", {31'b0, mem_en}, 32'(c == 1 || c == 6));
         check("sim_dbg_ack", {31'b0, dbg_ack}, 32'(c == 9));
         if (c == 6) check("sim_dbg_addr", mem_addr, 32'h200);
         if (c == 9) check("sim_dbg_rdata", dbg_rdata, 32'hCAFE_F00D);
      end

      // debug write then read-back; a write leaves dbg_rdata alone
      run_dbg(1'b1, 32'h600, 32'h0BAD_C0DE, 32'hCAFE_F00D);
      run_dbg(1'b0, 32'h600, 32'h0, 32'h0BAD_C0DE);

      // starvation: continuous core loads with dbg_req held
      st_addr[0] = 32'h400; st_addr[1] = 32'h404; st_addr[2] = 32'h408;
      foreach (done_at[i]) done_at[i] = -1;
      ack_at = -1; idx = 0; done_prev = 1'b0; ack_prev = 1'b0;
      cyc();
      core_ctrl = 2'b10; core_addr = st_addr[0];
      dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h300;
      acc_q.push_back('{st_addr[0], 1'b0, 32'h0});
      acc_q.push_back('{st_addr[1], 1'b0, 32'h0});
      acc_q.push_back('{32'h300, 1'b0, 32'h0});
      acc_q.push_back('{st_addr[2], 1'b0, 32'h0});
      for (int i = 0; i < 3; i++) core_q.push_back(mem_rd(st_addr[i]));
      dbg_q.push_back(mem_rd(32'h300));
      for (int c = 0; c < 30; c++) begin
         if (c > 0) begin
            cyc();
            if (done_prev) begin
               idx++;
               if (idx >= 3) core_ctrl = 2'b00;
               else          core_addr = st_addr[idx];
            end
            if (ack_prev) dbg_req = 1'b0;
         end
         #1;
         done_prev = (core_ctrl != 2'b00) && !core_stall;
         ack_prev  = dbg_ack;
         if (done_prev && idx < 3) done_at[idx] = c;
         if (ack_prev && ack_at < 0) ack_at = c;
         if (c >= 10 && c <= 14) check("starve_core_held", {31'b0, core_stall}, 32'd1);
      end
      check("starve_core0_done", 32'(done_at[0]), 32'd4);
      check("starve_core1_done", 32'(done_at[1]), 32'd9);
      check("starve_dbg_ack", 32'(ack_at), 32'd14);
      check("starve_core2_done", 32'(done_at[2]), 32'd19);

      // asynchronous reset during WAIT, then one fresh debug access
      cyc();
      dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h500;
      acc_q.push_back('{32'h500, 1'b0, 32'h0});
      cyc(); cyc();
      reset_n = 1'b0;
      #1;
      check("rmid_mem_en", {31'b0, mem_en}, 32'd0);
      check("rmid_mem_we", {31'b0, mem_we}, 32'd0);
      check("rmid_mem_addr", mem_addr, 32'd0);
      check("rmid_dbg_ack", {31'b0, dbg_ack}, 32'd0);
      check("rmid_core_rdata", core_rdata, 32'd0);
      check("rmid_dbg_rdata", dbg_rdata, 32'd0);
      cyc(); cyc();
      reset_n = 1'b1;
      acc_q.push_back('{32'h500, 1'b0, 32'h0});
      dbg_q.push_back(mem_rd(32'h500));
      wait_dbg_ack("rst_fresh", LAT_A + 2, mem_rd(32'h500));

      // MEM_LAT=1 instance, instance A parked in reset
      cyc(); reset_n = 1'b0; reset_n_b = 1'b1;
      cyc(); #1;
      check("b_idle_mem_en", {31'b0, mem_en_b}, 32'd0);
      cyc();
      core_ctrl = 2'b10; core_addr = 32'h100;
      #1;
      check("b_stall_c0", {31'b0, core_stall_b}, 32'd1);
      cyc(); #1;
      check("b_mem_en_c1", {31'b0, mem_en_b}, 32'd1);
      check("b_mem_addr_c1", mem_addr_b, 32'h100);
      check("b_stall_c1", {31'b0, core_stall_b}, 32'd1);
      cyc(); #1;
      check("b_stall_c2", {31'b0, core_stall_b}, 32'd1);
      check("b_mem_en_c2", {31'b0, mem_en_b}, 32'd0);
      cyc(); #1;
      check("b_stall_c3", {31'b0, core_stall_b}, 32'd0);
      check("b_rdata_c3", core_rdata_b, 32'hDEAD_BEEF);
      cyc(); core_ctrl = 2'b00;
      cyc(); cyc();

      check("acc_q_left", 32'(acc_q.size()), 32'd0);
      check("core_q_left", 32'(core_q.size()), 32'd0);
      check("dbg_q_left", 32'(dbg_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
